// File: rtl/node_sequencer.sv
// Route-level mission controller: steps through a programmable per-node action table,
// hands motor ownership to the line follower or turn executor, and tracks node/lap progress.
module node_sequencer #(
  parameter int ROUTE_LEN     = 8,
  parameter int NUM_LAPS      = 2,
  parameter int TURN_TIMEOUT  = 50000000,
  parameter int PROBE_TIMEOUT = 100000000,
  parameter int EXIT_CYCLES   = 1000000
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       start,
  input  logic       node,
  input  logic       cfg_we,
  input  logic [3:0] cfg_addr,
  input  logic [1:0] cfg_action,
  input  logic       turn_done,
  input  logic       probe_done,
  output logic       turn_req,
  output logic       turn_dir,
  output logic       probe_req,
  output logic [1:0] motor_sel,
  output logic [4:0] node_count,
  output logic [1:0] lap,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FOLLOW = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_TURN   = 3'd3;
  localparam logic [2:0] S_PROBE  = 3'd4;
  localparam logic [2:0] S_EXIT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [1:0] MOTOR_STOP   = 2'b00;
  localparam logic [1:0] MOTOR_FOLLOW = 2'b01;
  localparam logic [1:0] MOTOR_TURN   = 2'b10;

  localparam logic [26:0] TIMER_MAX   = '1;
  localparam logic [26:0] TURN_LIMIT  = 27'(TURN_TIMEOUT);
  localparam logic [26:0] PROBE_LIMIT = 27'(PROBE_TIMEOUT);
  localparam logic [26:0] EXIT_LIMIT  = 27'(EXIT_CYCLES);
  localparam logic [4:0]  COUNT_LIMIT = 5'(ROUTE_LEN);
  localparam logic [1:0]  LAP_LIMIT   = 2'(NUM_LAPS);

  logic [2:0]  state_reg, state_next;
  logic [26:0] timer_reg, timer_next;
  logic [26:0] timer_inc;
  logic [26:0] exit_cnt;
  logic        arm_reg, arm_next;
  logic        node_q_reg;
  logic        node_rise;
  logic [4:0]  node_count_reg, node_count_next;
  logic [1:0]  lap_reg, lap_next;
  logic        turn_dir_reg, turn_dir_next;
  logic        enter_exit;

  logic [1:0]  motor_sel_reg, motor_sel_next;
  logic        turn_req_reg, turn_req_next;
  logic        probe_req_reg, probe_req_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        fault_reg, fault_next;

  // Route table: 16-deep so any 4-bit address indexes safely; only entries below ROUTE_LEN are written
  logic [1:0]  route_mem [0:15];
  logic [1:0]  act_reg;
  logic        mem_we;

  assign mem_we    = (state_reg == S_IDLE) && cfg_we && ({1'b0, cfg_addr} < COUNT_LIMIT);
  assign timer_inc = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + 27'd1;
  assign node_rise = node & ~node_q_reg;

  // Registered read; node_count is stable for at least one cycle before DECODE uses act_reg
  always_ff @(posedge clk_50) begin
    if (mem_we) begin
      route_mem[cfg_addr] <= cfg_action;
    end
    act_reg <= route_mem[node_count_reg[3:0]];
  end

  always_comb begin
    state_next      = state_reg;
    arm_next        = arm_reg;
    node_count_next = node_count_reg;
    lap_next        = lap_reg;
    turn_dir_next   = turn_dir_reg;
    exit_cnt        = '0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next      = S_FOLLOW;
          node_count_next = '0;
          lap_next        = '0;
        end
      end
      S_FOLLOW: begin
        if (node_rise && arm_reg) begin
          state_next = S_DECODE;
          arm_next   = 1'b0;
        end
      end
      S_DECODE: begin
        case (act_reg)
          2'b00:   state_next = S_EXIT;
          2'b11:   state_next = S_PROBE;
          default: begin
            state_next    = S_TURN;
            turn_dir_next = act_reg[1];
          end
        endcase
      end
      S_TURN: begin
        // A completion in the same cycle as the timeout still counts as success
        if (turn_done) begin
          state_next = S_EXIT;
        end else if (timer_inc == TURN_LIMIT) begin
          state_next = S_FAULT;
        end
      end
      S_PROBE: begin
        if (probe_done) begin
          state_next = S_EXIT;
        end else if (timer_inc == PROBE_LIMIT) begin
          state_next = S_FAULT;
        end
      end
      S_EXIT: begin
        exit_cnt = node ? '0 : timer_inc;
        if (lap_reg == LAP_LIMIT) begin
          state_next = S_DONE;
        end else if (exit_cnt == EXIT_LIMIT) begin
          state_next = S_FOLLOW;
          arm_next   = 1'b1;
        end
      end
      default: begin
        state_next = state_reg;
      end
    endcase

    enter_exit = (state_next == S_EXIT) && (state_reg != S_EXIT);
    if (enter_exit) begin
      if (node_count_reg + 5'd1 == COUNT_LIMIT) begin
        node_count_next = '0;
        lap_next        = lap_reg + 2'd1;
      end else begin
        node_count_next = node_count_reg + 5'd1;
      end
    end

    // In EXIT the timer doubles as the consecutive node-low counter
    if (state_next != state_reg) begin
      timer_next = '0;
    end else if (state_reg == S_EXIT) begin
      timer_next = exit_cnt;
    end else begin
      timer_next = timer_inc;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with state_reg
  always_comb begin
    motor_sel_next = MOTOR_STOP;
    turn_req_next  = 1'b0;
    probe_req_next = 1'b0;
    busy_next      = 1'b1;
    done_next      = 1'b0;
    fault_next     = 1'b0;
    case (state_next)
      S_FOLLOW, S_EXIT: motor_sel_next = MOTOR_FOLLOW;
      S_TURN: begin
        motor_sel_next = MOTOR_TURN;
        turn_req_next  = 1'b1;
      end
      S_PROBE:  probe_req_next = 1'b1;
      S_IDLE:   busy_next      = 1'b0;
      S_DONE: begin
        busy_next = 1'b0;
        done_next = 1'b1;
      end
      S_FAULT: begin
        busy_next  = 1'b0;
        fault_next = 1'b1;
      end
      default: motor_sel_next = MOTOR_STOP;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      timer_reg      <= '0;
      arm_reg        <= 1'b1;
      node_q_reg     <= 1'b0;
      node_count_reg <= '0;
      lap_reg        <= '0;
      turn_dir_reg   <= 1'b0;
      motor_sel_reg  <= MOTOR_STOP;
      turn_req_reg   <= 1'b0;
      probe_req_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      arm_reg        <= arm_next;
      node_q_reg     <= node;
      node_count_reg <= node_count_next;
      lap_reg        <= lap_next;
      turn_dir_reg   <= turn_dir_next;
      motor_sel_reg  <= motor_sel_next;
      turn_req_reg   <= turn_req_next;
      probe_req_reg  <= probe_req_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      fault_reg      <= fault_next;
    end
  end

  assign turn_req   = turn_req_reg;
  assign turn_dir   = turn_dir_reg;
  assign probe_req  = probe_req_reg;
  assign motor_sel  = motor_sel_reg;
  assign node_count = node_count_reg;
  assign lap        = lap_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign fault      = fault_reg;

endmodule
